// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: frame states,
// header bit positions and the delta saturation helpers.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_st_e;
  typedef logic [1:0] pkt_idx_t;

  localparam int HDR_L    = 0;
  localparam int HDR_R    = 1;
  localparam int HDR_M    = 2;
  localparam int HDR_SYNC = 3;
  localparam int HDR_XS   = 4;
  localparam int HDR_YS   = 5;
  localparam int HDR_XO   = 6;
  localparam int HDR_YO   = 7;

  localparam logic [8:0] SAT_POS = 9'h0FF;
  localparam logic [8:0] SAT_NEG = 9'h100;

  function automatic logic [8:0] sat_delta(input logic sgn, input logic ovf,
                                           input logic [7:0] mag);
    if (ovf) return sgn ? SAT_NEG : SAT_POS;
    return {sgn, mag};
  endfunction

  // -(-256) does not fit in 9 bits, so it clamps to +255
  function automatic logic [8:0] neg_delta(input logic [8:0] v);
    if (v == SAT_NEG) return SAT_POS;
    return ~v + 9'd1;
  endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Raw PS/2 lines in, decoded mouse state out.
interface ps2_mouse_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] mouse_x;
  logic [8:0] mouse_y;
  logic       mouse_left;
  logic       mouse_right;
  logic       mouse_middle;
  logic       input_pulse;
  logic [7:0] err_count;

  modport master (output ps2_clk, ps2_data,
                  input  mouse_x, mouse_y, mouse_left, mouse_right, mouse_middle,
                         input_pulse, err_count);
  modport slave  (input  ps2_clk, ps2_data,
                  output mouse_x, mouse_y, mouse_left, mouse_right, mouse_middle,
                         input_pulse, err_count);
endinterface

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: sync + run-length filter on both lines, 11-bit frame
// FSM sampling on filtered clock falls, and an inactivity timeout.
module ps2_rx_byte
  import ps2_mouse_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pkt_busy,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       timeout
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // index 0 = clock line, index 1 = data line
  logic [1:0]         sync1_q, sync2_q, filt_q, filt_d;
  logic [1:0][CW-1:0] fcnt_q, fcnt_d;

  frame_st_e   state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        vld_q, vld_d, err_q, err_d, to_q, to_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        fall, sdat;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == CW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                  fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign fall = filt_q[0] & ~filt_d[0];
  assign sdat = filt_q[1];

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    tcnt_d  = tcnt_q;
    if (fall) begin
      tcnt_d = '0;
      case (state_q)
        IDLE:   if (!sdat) begin
                  state_d = DATA;
                  bit_d   = '0;
                  par_d   = 1'b0;
                end
        DATA:   begin
                  shreg_d = {sdat, shreg_q[7:1]};
                  par_d   = par_q ^ sdat;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = PARITY;
                end
        // par_q now holds "parity ok" for the stop-bit decision
        PARITY: begin
                  par_d   = par_q ^ sdat;
                  state_d = STOP;
                end
        default: begin
                  vld_d   = sdat & par_q;
                  err_d   = ~(sdat & par_q);
                  state_d = IDLE;
                end
      endcase
    end else if (state_q != IDLE || pkt_busy) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt_d  = '0;
        to_d    = 1'b1;
        state_d = IDLE;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      fcnt_q  <= '0;
      state_q <= IDLE;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      sync1_q <= {ps2_data, ps2_clk};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      to_q    <= to_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign data_byte  = shreg_q;
  assign byte_valid = vld_q;
  assign byte_err   = err_q;
  assign timeout    = to_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet decoder: assembles 3-byte packets from ps2_rx_byte and
// publishes saturated signed deltas, buttons and a per-packet toggle.
module ps2_mouse_rx
  import ps2_mouse_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 96000,
  parameter bit INVERT_Y       = 1'b0
) (
  input  logic           clk_sys,
  input  logic           reset,
  ps2_mouse_rx_if.slave  bus
);
  logic [7:0] data_byte;
  logic       byte_valid, byte_err, timeout;

  pkt_idx_t   idx_q, idx_d;
  logic [7:0] hdr_q, hdr_d, b1_q, b1_d, b2_q, b2_d;
  logic       commit_q, commit_d;
  logic [8:0] x_q, x_d, y_q, y_d, xs, ys;
  logic [2:0] btn_q, btn_d;
  logic       pulse_q, pulse_d;
  logic [7:0] err_q, err_d;

  ps2_rx_byte #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk_sys),
    .rst       (reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .pkt_busy  (idx_q != 2'd0),
    .data_byte (data_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .timeout   (timeout)
  );

  assign xs = sat_delta(hdr_q[HDR_XS], hdr_q[HDR_XO], b1_q);
  assign ys = sat_delta(hdr_q[HDR_YS], hdr_q[HDR_YO], b2_q);

  always_comb begin
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    commit_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    btn_d    = btn_q;
    pulse_d  = pulse_q;
    err_d    = err_q;
    if (byte_err || timeout) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      case (idx_q)
        2'd0:    if (data_byte[HDR_SYNC]) begin
                   hdr_d = data_byte;
                   idx_d = 2'd1;
                 end
        2'd1:    begin
                   b1_d  = data_byte;
                   idx_d = 2'd2;
                 end
        default: begin
                   b2_d     = data_byte;
                   commit_d = hdr_q[HDR_SYNC];
                   idx_d    = 2'd0;
                 end
      endcase
    end
    if (commit_q) begin
      x_d     = xs;
      y_d     = INVERT_Y ? neg_delta(ys) : ys;
      btn_d   = {hdr_q[HDR_M], hdr_q[HDR_R], hdr_q[HDR_L]};
      pulse_d = ~pulse_q;
    end
    if ((byte_err || timeout) && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      idx_q    <= 2'd0;
      hdr_q    <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      commit_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      btn_q    <= '0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      hdr_q    <= hdr_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      commit_q <= commit_d;
      x_q      <= x_d;
      y_q      <= y_d;
      btn_q    <= btn_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  assign bus.mouse_x      = x_q;
  assign bus.mouse_y      = y_q;
  assign bus.mouse_left   = btn_q[0];
  assign bus.mouse_right  = btn_q[1];
  assign bus.mouse_middle = btn_q[2];
  assign bus.input_pulse  = pulse_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench: two decoders (INVERT_Y 0 and 1) fed by one bit-banged
// PS/2 stream, checked against hand-computed packet results.
module tb_ps2_mouse_rx;
  localparam int HALF = 20;
  localparam int TO   = 1000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int vecs = 0;
  int miscompares = 0;
  int tog = 0;
  int exp_tog = 0;
  logic exp_pulse = 1'b0;
  logic prev_pulse;

  ps2_mouse_rx_if b0 ();
  ps2_mouse_rx_if b1 ();
  assign b0.ps2_clk  = ps2_clk;
  assign b0.ps2_data = ps2_data;
  assign b1.ps2_clk  = ps2_clk;
  assign b1.ps2_data = ps2_data;

  ps2_mouse_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .INVERT_Y(1'b0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .bus(b0));
  ps2_mouse_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .INVERT_Y(1'b1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .bus(b1));

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (reset) prev_pulse <= 1'b0;
    else begin
      if (b0.input_pulse !== prev_pulse) tog <= tog + 1;
      prev_pulse <= b0.input_pulse;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(1'b1);
    repeat (100) @(posedge clk_sys);
  endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y);
    send_byte(h, 1'b0);
    send_byte(x, 1'b0);
    send_byte(y, 1'b0);
    exp_pulse = ~exp_pulse;
    exp_tog++;
  endtask

  task automatic check_out(input string tag, input logic [8:0] x, input logic [8:0] y,
                           input logic [8:0] yinv, input logic [2:0] btn,
                           input logic [7:0] errs);
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    chk({tag, ".x"},    32'(b0.mouse_x), 32'(x));
    chk({tag, ".y"},    32'(b0.mouse_y), 32'(y));
    chk({tag, ".yinv"}, 32'(b1.mouse_y), 32'(yinv));
    chk({tag, ".xinv"}, 32'(b1.mouse_x), 32'(x));
    chk({tag, ".btn"},  32'({b0.mouse_middle, b0.mouse_right, b0.mouse_left}), 32'(btn));
    chk({tag, ".pulse"}, 32'(b0.input_pulse), 32'(exp_pulse));
    chk({tag, ".pulse1"}, 32'(b1.input_pulse), 32'(exp_pulse));
    chk({tag, ".toggles"}, 32'(tog), 32'(exp_tog));
    chk({tag, ".err"},  32'(b0.err_count), 32'(errs));
  endtask

  initial begin
    repeat (5) @(posedge clk_sys);
    reset = 1'b0;
    check_out("reset", 9'h000, 9'h000, 9'h000, 3'b000, 8'd0);

    send_pkt(8'h09, 8'h10, 8'h00);
    check_out("basic", 9'h010, 9'h000, 9'h000, 3'b001, 8'd0);

    send_pkt(8'h38, 8'hF0, 8'h01);
    check_out("neg", 9'h1F0, 9'h101, 9'h0FF, 3'b000, 8'd0);

    send_pkt(8'h48, 8'h20, 8'h00);
    check_out("xovf_pos", 9'h0FF, 9'h000, 9'h000, 3'b000, 8'd0);

    send_pkt(8'h58, 8'h20, 8'h00);
    check_out("xovf_neg", 9'h100, 9'h000, 9'h000, 3'b000, 8'd0);

    send_byte(8'h00, 1'b0);
    send_pkt(8'h0A, 8'h05, 8'h03);
    check_out("nosync", 9'h005, 9'h003, 9'h1FD, 3'b010, 8'd0);

    send_byte(8'h09, 1'b0);
    send_byte(8'h33, 1'b1);
    send_pkt(8'h0C, 8'h07, 8'h02);
    check_out("badpar", 9'h007, 9'h002, 9'h1FE, 3'b100, 8'd1);

    send_byte(8'h09, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (TO + 500) @(posedge clk_sys);
    send_pkt(8'h08, 8'h22, 8'h44);
    check_out("timeout", 9'h022, 9'h044, 9'h1BC, 3'b000, 8'd2);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk_sys);
    reset = 1'b1;
    repeat (5) @(posedge clk_sys);
    reset = 1'b0;
    exp_pulse = 1'b0;
    check_out("midreset", 9'h000, 9'h000, 9'h000, 3'b000, 8'd0);

    send_pkt(8'h09, 8'h01, 8'h02);
    check_out("postreset", 9'h001, 9'h002, 9'h1FE, 3'b001, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
